// File: rtl/mem_access.sv
// mem_access: memory-stage load/store unit driving an SRAM-like req/addr_ok/data_ok bus.
// Optional misaligned-address exceptions are enabled by defining MEM_ADDR_EXC_EN.
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [7:0]        memop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rdata_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [ADDR_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [ADDR_W-1:0] data_rdata
);
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_CANCEL} state_t;

  typedef struct packed {
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wdata;
  } req_t;

  function automatic logic is_mem(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2'd1;
      EXE_LW_OP, EXE_SW_OP:             return 2'd2;
      default:                          return 2'd0;
    endcase
  endfunction

  state_t            state, state_nxt;
  req_t              cap;
  logic [ADDR_W-1:0] rdata_q, addr_cap, ld_val;
  logic              mem_op, addr_err, start;

  assign mem_op = is_mem(memop_i);

`ifdef MEM_ADDR_EXC_EN
  logic              misal;
  logic [ADDR_W-1:0] badv_q;
  assign misal = ((op_size(memop_i) == 2'd1) && addr_i[0]) ||
                 ((op_size(memop_i) == 2'd2) && (addr_i[1:0] != 2'b00));
  assign addr_err   = valid_i & mem_op & misal;
  assign adel_o     = addr_err & ~is_store(memop_i);
  assign ades_o     = addr_err &  is_store(memop_i);
  assign badvaddr_o = addr_err ? addr_i : badv_q;
  assign addr_cap   = addr_i;

  always_ff @(posedge clk or posedge rst)
    if (rst)           badv_q <= '0;
    else if (addr_err) badv_q <= addr_i;
`else
  assign addr_err   = 1'b0;
  assign adel_o     = 1'b0;
  assign ades_o     = 1'b0;
  assign badvaddr_o = '0;

  // Without exceptions the low bits are simply dropped to keep the bus aligned.
  always_comb begin
    addr_cap = addr_i;
    case (op_size(memop_i))
      2'd1:    addr_cap = {addr_i[ADDR_W-1:1], 1'b0};
      2'd2:    addr_cap = {addr_i[ADDR_W-1:2], 2'b00};
      default: addr_cap = addr_i;
    endcase
  end
`endif

  assign start = valid_i & mem_op & ~flush_i & ~addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cap     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start)
        cap <= '{op: memop_i, addr: addr_cap, wdata: wdata_i};
      if (state == S_WAIT && data_data_ok && !flush_i)
        rdata_q <= ld_val;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    case (state)
      S_IDLE: begin
        stall_o = start;
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (data_addr_ok) state_nxt = flush_i ? S_CANCEL : S_WAIT;
        else if (flush_i) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (flush_i)           state_nxt = S_CANCEL;
        else if (data_data_ok) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      S_CANCEL: begin
        // Hold back the next mem op until the orphaned response drains.
        stall_o = valid_i & mem_op & ~addr_err;
        if (data_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    data_wstrb = 4'b1111;
    data_wdata = cap.wdata;
    case (data_size)
      2'd0: begin
        data_wstrb = 4'b0001 << cap.addr[1:0];
        data_wdata = {4{cap.wdata[7:0]}};
      end
      2'd1: begin
        data_wstrb = cap.addr[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{cap.wdata[15:0]}};
      end
      default: ;
    endcase
    if (!data_wr) data_wstrb = 4'b0000;
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_rdata[{cap.addr[1:0], 3'b000} +: 8];
    half_sel = cap.addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (cap.op)
      EXE_LB_OP:  ld_val = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: ld_val = {24'b0, byte_sel};
      EXE_LH_OP:  ld_val = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: ld_val = {16'b0, half_sel};
      EXE_LW_OP:  ld_val = data_rdata;
      default:    ld_val = '0;
    endcase
  end

  assign data_req  = (state == S_REQ);
  assign done_o    = (state == S_DONE);
  assign rdata_o   = rdata_q;
  assign data_addr = cap.addr;
  assign data_wr   = is_store(cap.op);
  assign data_size = op_size(cap.op);

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed test-plan sequences plus randomized bus/pipeline traffic,
// checked every cycle against a transaction-level model of the load/store unit.
`timescale 1ns/1ps
module tb_mem_access;
  localparam logic [7:0] LB = 8'hE0, LBU = 8'hE4, LH = 8'hE1, LHU = 8'hE5, LW = 8'hE3;
  localparam logic [7:0] SB = 8'hE8, SH = 8'hE9, SW = 8'hEB;

  logic        clk = 0, rst = 1, valid = 0, flush = 0;
  logic [7:0]  memop = 0;
  logic [31:0] addr = 0, wdata = 0, data_rdata = 0;
  logic        data_addr_ok = 0, data_data_ok = 0;
  logic        stall, done, adel, ades, data_req, data_wr;
  logic [31:0] rdata, badvaddr, data_addr, data_wdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .valid_i(valid), .flush_i(flush), .memop_i(memop),
    .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done), .rdata_o(rdata),
    .adel_o(adel), .ades_o(ades), .badvaddr_o(badvaddr), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [7:0] op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit is_st(input logic [7:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  // Load result from the raw word using shifts and masks.
  function automatic logic [31:0] ld_val(input logic [7:0] op, input logic [31:0] a,
                                         input logic [31:0] raw);
    int off;
    logic [31:0] b, h;
    off = int'(a % 4);
    b = (raw >> (8 * off)) & 32'hFF;
    h = (raw >> (8 * (off - off % 2))) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      LHU:     return h;
      LW:      return raw;
      default: return 0;
    endcase
  endfunction

  // Model: flags for "request pending", "data pending", "cancelled", "done pulse".
  bit          m_req, m_dat, m_cancel, m_done;
  logic [7:0]  m_op;
  logic [31:0] m_addr, m_wdata, m_rdata, m_badv;
  bit          e_stall_q;

  function automatic bit m_err();
`ifdef MEM_ADDR_EXC_EN
    int n;
    n = nbytes(memop);
    return valid && n != 0 && (addr % 32'(n)) != 0;
`else
    return 0;
`endif
  endfunction

  function automatic bit m_start();
    return valid && nbytes(memop) != 0 && !flush && !m_err();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req = 0; m_dat = 0; m_cancel = 0; m_done = 0;
      m_op = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_badv = 0;
    end else begin
      if (m_err()) m_badv = addr;
      if (m_done) m_done = 0;
      else if (m_req) begin
        if (data_addr_ok) begin m_req = 0; m_dat = 1; m_cancel = flush; end
        else if (flush) m_req = 0;
      end else if (m_dat) begin
        if (m_cancel) begin
          if (data_data_ok) begin m_dat = 0; m_cancel = 0; end
        end else if (flush) m_cancel = 1;
        else if (data_data_ok) begin
          m_dat = 0; m_done = 1; m_rdata = ld_val(m_op, m_addr, data_rdata);
        end
      end else if (m_start()) begin
        m_req = 1; m_op = memop; m_wdata = wdata;
`ifdef MEM_ADDR_EXC_EN
        m_addr = addr;
`else
        m_addr = addr - addr % 32'(nbytes(memop));
`endif
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    bit idle, e_stall, err;
    int n;
    logic [31:0] e_wd;
    if (!rst) begin
      idle = !m_req && !m_dat && !m_done;
      err = m_err();
      e_stall = (idle && m_start()) || m_req || (m_dat && !m_cancel) ||
                (m_dat && m_cancel && valid && nbytes(memop) != 0 && !err);
      e_stall_q = e_stall;
      chk("stall", stall, e_stall);
      chk("req", data_req, m_req);
      chk("done", done, m_done);
      chk("adel", adel, err && !is_st(memop));
      chk("ades", ades, err && is_st(memop));
      chk("badvaddr", badvaddr, err ? addr : m_badv);
      if (m_done) chk("rdata", rdata, m_rdata);
      if (m_req) begin
        n = nbytes(m_op);
        e_wd = (n == 1) ? (m_wdata & 32'hFF) * 32'h0101_0101 :
               (n == 2) ? (m_wdata & 32'hFFFF) * 32'h0001_0001 : m_wdata;
        chk("bus_addr", data_addr, m_addr);
        chk("bus_wr", data_wr, is_st(m_op));
        chk("bus_size", data_size, (n == 1) ? 0 : (n == 2) ? 1 : 2);
        chk("bus_wstrb", data_wstrb, is_st(m_op) ? ((1 << n) - 1) << (m_addr % 4) : 0);
        if (is_st(m_op)) chk("bus_wdata", data_wdata, e_wd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ops [8];
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

    step;
    #2;
    chk("rst_req", data_req, 0);  chk("rst_done", done, 0);   chk("rst_stall", stall, 0);
    chk("rst_rdata", rdata, 0);   chk("rst_addr", data_addr, 0);
    chk("rst_adel", adel, 0);     chk("rst_badv", badvaddr, 0);
    step; rst = 0;
    step;

    // LB 0x1003, minimum latency
    valid = 1; memop = LB; addr = 32'h1003; data_rdata = 32'h80FF_FF7F;
    #2 chk("lb_c0_stall", stall, 1);
    step; addr_ok_set(1);
    #2 chk("lb_c1_req", data_req, 1); chk("lb_size", data_size, 0); chk("lb_wstrb", data_wstrb, 0);
    step; addr_ok_set(0); data_data_ok = 1;
    #2 chk("lb_c2_stall", stall, 1);
    step; data_data_ok = 0;
    #2 chk("lb_c3_done", done, 1); chk("lb_rdata", rdata, 32'hFFFF_FF80); chk("lb_c3_stall", stall, 0);
    step; valid = 0;

    // SH 0x2002
    valid = 1; memop = SH; addr = 32'h2002; wdata = 32'h1234_ABCD;
    step; addr_ok_set(1);
    #2 chk("sh_wr", data_wr, 1); chk("sh_size", data_size, 1);
    chk("sh_wstrb", data_wstrb, 4'b1100); chk("sh_wdata", data_wdata, 32'hABCD_ABCD);
    step; addr_ok_set(0); data_data_ok = 1;
    step; data_data_ok = 0;
    #2 chk("sh_done", done, 1); chk("sh_rdata", rdata, 0);
    step; valid = 0;

    // LHU 0x10 with slow handshakes
    valid = 1; memop = LHU; addr = 32'h10; data_rdata = 32'h0000_F00F;
    step;
    repeat (5) begin #2 chk("lhu_req_hold", data_req, 1); step; end
    addr_ok_set(1); step; addr_ok_set(0);
    repeat (5) begin #2 chk("lhu_wait_stall", stall, 1); step; end
    data_data_ok = 1; step; data_data_ok = 0;
    #2 chk("lhu_done", done, 1); chk("lhu_rdata", rdata, 32'h0000_F00F);
    step; valid = 0;

    // flush in WAIT, then a following LW is held off by CANCEL
    valid = 1; memop = LW; addr = 32'h40;
    step; addr_ok_set(1);
    step; addr_ok_set(0); flush = 1;
    step; flush = 0; addr = 32'h80;
    #2 chk("cxl_stall", stall, 1); chk("cxl_done", done, 0); chk("cxl_req", data_req, 0);
    step; data_data_ok = 1;
    #2 chk("cxl_ok_stall", stall, 1); chk("cxl_ok_done", done, 0);
    step; data_data_ok = 0;
    #2 chk("cxl_idle_stall", stall, 1);
    step;
    #2 chk("cxl_reissue", data_req, 1); chk("cxl_addr", data_addr, 32'h80);
    addr_ok_set(1); step; addr_ok_set(0); data_data_ok = 1;
    step; data_data_ok = 0;
    step; valid = 0;

    // misaligned LW 0x1002
    valid = 1; memop = LW; addr = 32'h1002;
`ifdef MEM_ADDR_EXC_EN
    #2 chk("mis_adel", adel, 1); chk("mis_badv", badvaddr, 32'h1002); chk("mis_stall", stall, 0);
    step;
    #2 chk("mis_noreq", data_req, 0);
    valid = 0;
`else
    step;
    #2 chk("mis_addr", data_addr, 32'h1000); chk("mis_adel", adel, 0);
    addr_ok_set(1); step; addr_ok_set(0); data_data_ok = 1;
    step; data_data_ok = 0;
    step; valid = 0;
`endif

    // async reset while in REQ
    valid = 1; memop = SB; addr = 32'h33; wdata = 32'h5A;
    step;
    #2 chk("rreq_req", data_req, 1);
    valid = 0; rst = 1;
    #1 chk("rreq_drop", data_req, 0); chk("rreq_stall", stall, 0);
    chk("rreq_addr", data_addr, 0); chk("rreq_wstrb", data_wstrb, 0);
    step; rst = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step;
      rst = ($urandom % 400 == 0);
      if (!e_stall_q) begin
        valid = ($urandom % 4 != 0);
        case ($urandom % 10)
          8:       memop = 8'h00;
          9:       memop = 8'($urandom);
          default: memop = ops[$urandom % 8];
        endcase
        addr = $urandom; wdata = $urandom;
      end
      flush = ($urandom % 16 == 0);
      data_addr_ok = ($urandom % 3 == 0);
      data_data_ok = ($urandom % 3 == 0);
      data_rdata = $urandom;
    end
    step; rst = 0; valid = 0; flush = 0;
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic addr_ok_set(input logic v);
    data_addr_ok = v;
  endtask

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage load/store unit, directly downstream of the execute ALU.
- Inputs: the 8-bit EXE_*_OP code and the effective address produced by the ALU (alu_out), plus rt store data.
- Drives an SRAM-like data bus (req/addr_ok/data_ok), formats store bytes, and extends load data.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, address and data bus width (only 32 supported).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- valid_i  in  1  instruction in M stage is valid
- flush_i  in  1  pipeline flush (exception/eret)
- memop_i  in  8  EXE_*_OP code from defines.vh
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (rt)
- stall_o  out  1  freeze pipeline
- done_o  out  1  one-cycle pulse: access complete
- rdata_o  out  32  extended load result, valid while done_o=1
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- badvaddr_o  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_wstrb  out  4  byte write strobes
- data_addr  out  32  bus address
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  data returned / write done
- data_rdata  in  32  raw read word

Behaviour:
- Mem ops: EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP. All other codes are ignored (no stall, no request).
- start = valid_i & memop is a mem op & ~flush_i & ~addr_err.
- FSM states: IDLE, REQ, WAIT, DONE, CANCEL.
  - IDLE: on start, capture op/addr/wdata into registers and go to REQ.
  - REQ: data_req=1 with all bus fields driven from the registers.
    - addr_ok=1: go to WAIT.
    - flush_i=1 and addr_ok=0: go to IDLE; req is dropped.
    - flush_i=1 and addr_ok=1 in the same cycle: go to CANCEL.
  - WAIT: data_req=0.
    - data_ok=1: latch the formatted read data and go to DONE.
    - flush_i=1: go to CANCEL (flush wins if simultaneous with data_ok).
  - DONE: done_o=1, stall_o=0, then IDLE unconditionally. The pipeline advances at this edge; no re-issue.
  - CANCEL: wait for data_ok, discard the data, go to IDLE. No done_o. data_req stays 0.
- stall_o = (IDLE & start) | REQ | WAIT | (CANCEL & valid_i & mem op).
- Minimum latency, start in cycle 0: REQ in c1 (addr_ok), WAIT in c2 (data_ok), DONE in c3. Stall is high c0–c2.
- Size and strobes:
  - Byte: size 0, wstrb = 1<<addr[1:0].
  - Half: size 1, wstrb 0011 or 1100 by addr[1].
  - Word: size 2, wstrb 1111.
  - Loads: wstrb 0000, data_wr=0.
- Store data: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW → wdata.
- Load extension:
  - Byte/half selected by addr[1:0] / addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Stores return rdata_o=0.
- data_addr = captured addr_i. No translation is done in this block.
- Reset (asynchronous): state IDLE. data_req, done_o, adel_o, ades_o all 0. rdata_o, badvaddr_o 0. Capture registers 0.
- Reset mid-transaction: return to IDLE immediately. A bus response in flight is the bus slave's responsibility (it is reset together).

Optional Feature:
- MEM_ADDR_EXC_EN defined:
  - Misaligned LH/LHU (addr[0]≠0) or LW (addr[1:0]≠0) sets adel_o.
  - Misaligned SH/SW sets ades_o.
  - Both are combinational in the same cycle as valid_i, with badvaddr_o=addr_i.
  - No request is issued and no stall.
  - adel_o/ades_o are 0 and badvaddr_o holds its previous value otherwise.
- Undefined:
  - adel_o = ades_o = 0; badvaddr_o is constant 0.
  - Low address bits are forced aligned: half → addr&~1, word → addr&~3.

Test Plan:
- LB addr 0x1003, data_rdata 0x80FF_FF7F, addr_ok and data_ok each 1 cycle late → size 0, wstrb 0000. done_o in c3 with rdata_o 0xFFFF_FF80. stall_o high c0–c2.
- SH addr 0x2002, wdata 0x1234_ABCD → data_wr=1, size 1, wstrb 1100, data_wdata 0xABCD_ABCD. done_o after data_ok, rdata_o 0.
- LHU addr 0x10, rdata 0x0000_F00F, addr_ok/data_ok held 0 for 5 cycles → req stays high, stall stays high, then rdata_o 0x0000_F00F.
- flush_i in WAIT, then data_ok 2 cycles later → CANCEL, no done_o. A following LW waits (stall_o=1) until data_ok, then issues.
- With MEM_ADDR_EXC_EN: LW addr 0x1002 → adel_o=1, badvaddr_o 0x1002, data_req never asserted, stall_o 0. Without the macro: data_addr 0x1000.
- rst asserted while in REQ → data_req drops in the same cycle (asynchronous), state IDLE, all outputs 0.
